// File: rtl/visbuffer.sv
`default_nettype none
// ============================================================================
// Module : visbuffer
// Ping-pong frame buffer: captures framed visibility sets into two banks and
// streams each completed set out on a valid/ready port.
// Rev    : 1.0
// ============================================================================
module visbuffer #(
   parameter int OBITS = 8,
   parameter int NSUMS = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             valid_i,
   input  logic             first_i,
   input  logic             last_i,
   input  logic [OBITS-1:0] data_i,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast,
   output logic [OBITS-1:0] m_tdata,
   output logic             overflow_o,
   output logic             error_o
);
   localparam int ABITS = $clog2(NSUMS);
   localparam logic [ABITS-1:0] LAST_ADDR = ABITS'(NSUMS - 1);
   localparam logic [ABITS-1:0] ONE_ADDR  = ABITS'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   logic [OBITS-1:0] mem [2*NSUMS];

   logic [1:0]       state, state_n;
   logic [ABITS-1:0] waddr, waddr_n, wr_addr, raddr;
   logic             wbank, rbank, ibank;
   logic [1:0]       full, full_eff, full_n;
   logic             wr_en, set_full, ovf_n, err_n;
   logic             release_fr, load_out, rd_en, rd_valid, rd_last;
   logic [OBITS-1:0] rd_data;

   assign release_fr = m_tvalid && m_tready && m_tlast;
   assign load_out   = !m_tvalid || m_tready;
   // Issue pointer runs ahead of rbank so the next bank streams without a bubble.
   assign rd_en      = full[ibank] && (!rd_valid || load_out);

   // A release in this cycle frees the bank for a frame starting in this cycle.
   always_comb begin
      full_eff = full;
      if (release_fr) full_eff[rbank] = 1'b0;
      full_n = full_eff;
      if (set_full) full_n[wbank] = 1'b1;
   end

   always_comb begin
      state_n  = state;
      waddr_n  = waddr;
      wr_en    = 1'b0;
      wr_addr  = waddr;
      set_full = 1'b0;
      ovf_n    = 1'b0;
      err_n    = 1'b0;
      if (valid_i) begin
         case (state)
            S_IDLE: begin
               if (first_i) begin
                  if (full_eff[wbank]) begin
                     ovf_n = 1'b1;
                     if (!last_i) state_n = S_DROP;
                  end else begin
                     wr_en   = 1'b1;
                     wr_addr = '0;
                     if (last_i) begin
                        err_n = 1'b1;
                     end else begin
                        state_n = S_FILL;
                        waddr_n = ONE_ADDR;
                     end
                  end
               end
            end
            S_FILL: begin
               wr_en = 1'b1;
               if (first_i) begin
                  wr_addr = '0;
                  err_n   = 1'b1;
                  if (last_i) state_n = S_IDLE;
                  else        waddr_n = ONE_ADDR;
               end else if (waddr == LAST_ADDR) begin
                  if (last_i) begin
                     set_full = 1'b1;
                     state_n  = S_IDLE;
                  end else begin
                     err_n   = 1'b1;
                     state_n = S_DROP;
                  end
               end else if (last_i) begin
                  err_n   = 1'b1;
                  state_n = S_IDLE;
               end else begin
                  waddr_n = waddr + ONE_ADDR;
               end
            end
            S_DROP: begin
               if (last_i) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_IDLE;
         waddr      <= '0;
         wbank      <= 1'b0;
         rbank      <= 1'b0;
         full       <= '0;
         overflow_o <= 1'b0;
         error_o    <= 1'b0;
      end else begin
         state      <= state_n;
         waddr      <= waddr_n;
         full       <= full_n;
         overflow_o <= ovf_n;
         error_o    <= err_n;
         if (set_full)   wbank <= ~wbank;
         if (release_fr) rbank <= ~rbank;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[{wbank, wr_addr}] <= data_i;
      if (rd_en) rd_data <= mem[{ibank, raddr}];
   end

   // Two-stage read pipeline: RAM output register, then the stream register.
   always_ff @(posedge clock) begin
      if (reset) begin
         ibank    <= 1'b0;
         raddr    <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         m_tvalid <= 1'b0;
         m_tlast  <= 1'b0;
         m_tdata  <= '0;
      end else begin
         if (rd_en) begin
            rd_valid <= 1'b1;
            rd_last  <= (raddr == LAST_ADDR);
            if (raddr == LAST_ADDR) begin
               raddr <= '0;
               ibank <= ~ibank;
            end else begin
               raddr <= raddr + ONE_ADDR;
            end
         end else if (load_out) begin
            rd_valid <= 1'b0;
         end
         if (load_out) begin
            m_tvalid <= rd_valid;
            m_tlast  <= rd_valid && rd_last;
            if (rd_valid) m_tdata <= rd_data;
         end
      end
   end

endmodule
`default_nettype wire
